activation_pipe: RTL and testbench

- Multi-lane, pipelined, signed fixed-point activation unit; parametrised successor to the single-lane combinational ReLU.
- Applies a runtime-selectable function (pass, ReLU, leaky ReLU, clamped ReLU) to LANES packed Qm.n elements per beat.
- Sits between the MAC/accumulator output stage and the activation writeback buffer.
- Uses valid/ready handshakes on both sides.

---
 rtl/activation_pipe.sv | 172 +++++++++++++++++
 tb/tb_activation_pipe.sv | 314 +++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/activation_pipe.sv
// activation_pipe: per-lane pass / ReLU / leaky ReLU / clamped ReLU on LANES packed signed Qm.n elements.
// Latency: 2 cycles (S1 input register, S2 result register); throughput 1 beat/cycle.
// Backpressure: out_rdy low stalls S2, then S1; in_rdy is combinational from out_rdy (no skid buffer).
// Optional: define ACTIVATION_PIPE_STATS_EN to add the zero_cnt / clip_cnt output counters.
module activation_pipe #(
   parameter int WIDTH      = 16,
   parameter int FRAC       = 8,
   parameter int LANES      = 4,
   parameter int LEAK_SHIFT = 3,
   parameter int CLAMP_INT  = 6
) (
   input  logic                     clk,
   input  logic                     rst,
   input  logic                     in_val,
   output logic                     in_rdy,
   input  logic [WIDTH*LANES-1:0]   in_data,
   input  logic [1:0]               in_mode,
   output logic                     out_val,
   input  logic                     out_rdy,
   output logic [WIDTH*LANES-1:0]   out_data
`ifdef ACTIVATION_PIPE_STATS_EN
   ,
   output logic [31:0]              zero_cnt,
   output logic [31:0]              clip_cnt
`endif
);

   // Upper clamp bound, saturated to the largest positive element value.
   localparam longint MAX_POS   = (longint'(1) << (WIDTH - 1)) - 1;
   localparam longint BOUND_RAW = longint'(CLAMP_INT) << FRAC;
   localparam logic [WIDTH-1:0] CLAMP_MAX = (BOUND_RAW > MAX_POS) ? WIDTH'(MAX_POS) : WIDTH'(BOUND_RAW);
   localparam int CW = $clog2(LANES + 1);

   // One lane of the activation function; modes 0 pass, 1 ReLU, 2 leaky, 3 clamp.
   function automatic logic [WIDTH-1:0] act_lane(input logic [WIDTH-1:0] x, input logic [1:0] mode);
      logic signed [WIDTH-1:0] xs;
      logic signed [WIDTH-1:0] sh;
      logic [WIDTH-1:0]        y;
      xs = x;
      sh = xs >>> LEAK_SHIFT;   // kept separate so the shift stays arithmetic
      case (mode)
         2'd0:    y = x;
         2'd1:    y = xs[WIDTH-1] ? '0 : x;
         2'd2:    y = xs[WIDTH-1] ? sh : x;
         default: y = xs[WIDTH-1] ? '0 : ((xs > $signed(CLAMP_MAX)) ? CLAMP_MAX : x);
      endcase
      return y;
   endfunction

   logic                    s1_val_q, s1_val_d;
   logic [WIDTH*LANES-1:0]  s1_data_q, s1_data_d;
   logic [1:0]              s1_mode_q, s1_mode_d;
   logic                    s2_val_q, s2_val_d;
   logic [WIDTH*LANES-1:0]  s2_data_q, s2_data_d;
   logic [WIDTH*LANES-1:0]  act_data;
   logic                    s1_adv, s2_adv;

   // Stage advance: a stage may load when it is empty or its contents are leaving.
   always_comb begin
      s2_adv = !s2_val_q || out_rdy;
      s1_adv = !s1_val_q || s2_adv;
   end

   assign in_rdy   = s1_adv;
   assign out_val  = s2_val_q;
   assign out_data = s2_data_q;

   // Per-lane activation of the S1 contents.
   always_comb begin
      act_data = '0;
      for (int i = 0; i < LANES; i++) begin
         act_data[i*WIDTH +: WIDTH] = act_lane(s1_data_q[i*WIDTH +: WIDTH], s1_mode_q);
      end
   end

   // Next-state for both stages; data registers only load on an actual transfer.
   always_comb begin
      s1_val_d  = s1_val_q;
      s1_data_d = s1_data_q;
      s1_mode_d = s1_mode_q;
      s2_val_d  = s2_val_q;
      s2_data_d = s2_data_q;
      if (s1_adv) begin
         s1_val_d = in_val;
         if (in_val) begin
            s1_data_d = in_data;
            s1_mode_d = in_mode;
         end
      end
      if (s2_adv) begin
         s2_val_d = s1_val_q;
         if (s1_val_q) begin
            s2_data_d = act_data;
         end
      end
   end

   // Pipeline registers; reset discards any in-flight beats.
   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         s1_val_q  <= 1'b0;
         s1_data_q <= '0;
         s1_mode_q <= '0;
         s2_val_q  <= 1'b0;
         s2_data_q <= '0;
      end else begin
         s1_val_q  <= s1_val_d;
         s1_data_q <= s1_data_d;
         s1_mode_q <= s1_mode_d;
         s2_val_q  <= s2_val_d;
         s2_data_q <= s2_data_d;
      end
   end

`ifdef ACTIVATION_PIPE_STATS_EN
   logic [CW-1:0] zero_n, clip_n;
   logic [CW-1:0] s2_zero_q, s2_zero_d;
   logic [CW-1:0] s2_clip_q, s2_clip_d;
   logic [31:0]   zero_cnt_q, zero_cnt_d;
   logic [31:0]   clip_cnt_q, clip_cnt_d;

   // Per-beat counts of zeroed-negative lanes and upper-clamped lanes, carried alongside S2.
   always_comb begin
      zero_n = '0;
      clip_n = '0;
      for (int i = 0; i < LANES; i++) begin
         if (s1_data_q[i*WIDTH + WIDTH - 1] && s1_mode_q[0]) begin
            zero_n = zero_n + CW'(1);
         end
         if ((s1_mode_q == 2'd3) && !s1_data_q[i*WIDTH + WIDTH - 1] &&
             ($signed(s1_data_q[i*WIDTH +: WIDTH]) > $signed(CLAMP_MAX))) begin
            clip_n = clip_n + CW'(1);
         end
      end
   end

   // Counters advance only when a beat is actually handed downstream.
   always_comb begin
      s2_zero_d  = s2_zero_q;
      s2_clip_d  = s2_clip_q;
      zero_cnt_d = zero_cnt_q;
      clip_cnt_d = clip_cnt_q;
      if (s2_adv && s1_val_q) begin
         s2_zero_d = zero_n;
         s2_clip_d = clip_n;
      end
      if (s2_val_q && out_rdy) begin
         zero_cnt_d = zero_cnt_q + 32'(s2_zero_q);
         clip_cnt_d = clip_cnt_q + 32'(s2_clip_q);
      end
   end

   // Statistics registers.
   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         s2_zero_q  <= '0;
         s2_clip_q  <= '0;
         zero_cnt_q <= '0;
         clip_cnt_q <= '0;
      end else begin
         s2_zero_q  <= s2_zero_d;
         s2_clip_q  <= s2_clip_d;
         zero_cnt_q <= zero_cnt_d;
         clip_cnt_q <= clip_cnt_d;
      end
   end

   assign zero_cnt = zero_cnt_q;
   assign clip_cnt = clip_cnt_q;
`endif

endmodule

// File: tb/tb_activation_pipe.sv
// tb_activation_pipe: directed and random checks of activation_pipe (WIDTH 16, Q8.8, LANES 4).
// Expected values are hand-computed constants or come from an integer reference model.
// Counter checks are compiled in when ACTIVATION_PIPE_STATS_EN is defined.
module tb_activation_pipe;

   logic        clk;
   logic        rst;
   logic        in_val;
   logic        in_rdy;
   logic [63:0] in_data;
   logic [1:0]  in_mode;
   logic        out_val;
   logic        out_rdy;
   logic [63:0] out_data;
`ifdef ACTIVATION_PIPE_STATS_EN
   logic [31:0] zero_cnt;
   logic [31:0] clip_cnt;
`endif

   int tests = 0;
   int fails = 0;

   activation_pipe dut (
      .clk      (clk),
      .rst      (rst),
      .in_val   (in_val),
      .in_rdy   (in_rdy),
      .in_data  (in_data),
      .in_mode  (in_mode),
      .out_val  (out_val),
      .out_rdy  (out_rdy),
      .out_data (out_data)
`ifdef ACTIVATION_PIPE_STATS_EN
      ,
      .zero_cnt (zero_cnt),
      .clip_cnt (clip_cnt)
`endif
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
      tests++;
      assert (obs === exp) else begin
         fails++;
         $error("FAIL %s: observed %h expected %h", tag, obs, exp);
      end
   endtask

   // Advance to 1 time unit after the next rising edge; inputs change here.
   task automatic cyc();
      @(posedge clk);
      #1;
   endtask

   // Integer reference model for one lane (Q8.8, slope 1/8, bound 6.0 = 1536).
   function automatic logic [15:0] model_lane(input logic [15:0] x, input logic [1:0] m);
      int v;
      int r;
      v = int'($signed(x));
      case (m)
         2'd0:    r = v;
         2'd1:    r = (v < 0) ? 0 : v;
         2'd2:    r = (v < 0) ? (v - 7) / 8 : v;
         default: r = (v < 0) ? 0 : ((v > 1536) ? 1536 : v);
      endcase
      return 16'(r);
   endfunction

   function automatic logic [15:0] rnd_elem();
      logic [15:0] e;
      case ($urandom_range(5))
         0:       e = 16'h8000;
         1:       e = 16'h7FFF;
         2:       e = 16'hFFFF;
         3:       e = 16'h0600;
         default: e = 16'($urandom);
      endcase
      return e;
   endfunction

   // Send one beat with out_rdy high and check it two cycles later.
   task automatic send_one(input string tag, input logic [1:0] m, input logic [63:0] d, input logic [63:0] e);
      cyc();
      in_val  = 1'b1;
      in_mode = m;
      in_data = d;
      #1;
      chk({tag, "_in_rdy"}, 64'(in_rdy), 64'd1);
      cyc();
      in_val = 1'b0;
      cyc();
      #1;
      chk({tag, "_out_val"}, 64'(out_val), 64'd1);
      chk({tag, "_out_data"}, out_data, e);
      cyc();
      #1;
      chk({tag, "_drained"}, 64'(out_val), 64'd0);
   endtask

   localparam int NBEATS = 10000;
   localparam int BUDGET = 60000;

   logic [63:0] exp_q[$];
   int          zq[$];
   int          cq[$];

   initial begin
      logic [63:0] bp_beat [5];
      int          sent;
      int          rcvd;
      int          zero_tot;
      int          clip_tot;

      rst     = 1'b0;
      in_val  = 1'b1;
      in_mode = 2'd0;
      in_data = 64'h1234_5678_9ABC_DEF0;
      out_rdy = 1'b1;

      // Reset held with input offered: nothing may enter or leave.
      repeat (3) cyc();
      #1;
      chk("rst_out_val", 64'(out_val), 64'd0);
      chk("rst_out_data", out_data, 64'd0);
      cyc();
      rst    = 1'b1;
      in_val = 1'b0;
      for (int k = 0; k < 4; k++) begin
         cyc();
         #1;
         chk("post_rst_idle", 64'(out_val), 64'd0);
      end

      // Directed single beats.
      send_one("relu", 2'd1, 64'h0100_FF00_8000_7FFF, 64'h0100_0000_0000_7FFF);
      send_one("leaky", 2'd2, 64'hFF00_0200_FFFF_8000, 64'hFFE0_0200_FFFF_F000);
      send_one("clamp", 2'd3, 64'h0700_0600_05FF_FE00, 64'h0600_0600_05FF_0000);
      send_one("pass", 2'd0, 64'h8000_FFFF_1234_7FFF, 64'h8000_FFFF_1234_7FFF);
      send_one("clamp_max", 2'd3, 64'h7FFF_0601_0001_0000, 64'h0600_0600_0001_0000);

      // Backpressure: two beats accepted, then in_rdy drops and output holds.
      for (int k = 0; k < 5; k++) bp_beat[k] = {4{16'h1000 + 16'(k)}};
      cyc();
      out_rdy = 1'b0;
      in_val  = 1'b1;
      in_mode = 2'd0;
      in_data = bp_beat[0];
      #1;
      chk("bp_rdy0", 64'(in_rdy), 64'd1);
      cyc();
      in_data = bp_beat[1];
      #1;
      chk("bp_rdy1", 64'(in_rdy), 64'd1);
      cyc();
      in_data = bp_beat[2];
      for (int k = 0; k < 3; k++) begin
         #1;
         chk("bp_stall_rdy", 64'(in_rdy), 64'd0);
         chk("bp_stall_val", 64'(out_val), 64'd1);
         chk("bp_stall_data", out_data, bp_beat[0]);
         cyc();
      end
      out_rdy = 1'b1;
      for (int k = 0; k < 5; k++) begin
         if (k < 3) in_data = bp_beat[k + 2];
         else       in_val = 1'b0;
         #1;
         if (k < 3) chk("bp_resume_rdy", 64'(in_rdy), 64'd1);
         chk("bp_order_val", 64'(out_val), 64'd1);
         chk("bp_order_data", out_data, bp_beat[k]);
         cyc();
      end
      #1;
      chk("bp_empty", 64'(out_val), 64'd0);

      // Mode alternates every beat on the same input value.
      for (int c = 0; c < 9; c++) begin
         cyc();
         if (c < 6) begin
            in_val  = 1'b1;
            in_data = {4{16'hFF00}};
            in_mode = (c % 2 == 0) ? 2'd1 : 2'd2;
         end else begin
            in_val = 1'b0;
         end
         #1;
         if (c >= 2 && c < 8) begin
            chk("modesw_val", 64'(out_val), 64'd1);
            chk("modesw_data", out_data, (c % 2 == 0) ? 64'd0 : {4{16'hFFE0}});
         end else if (c == 8) begin
            chk("modesw_end", 64'(out_val), 64'd0);
         end
      end

      // Reset while a beat sits in S2 discards it immediately.
      cyc();
      out_rdy = 1'b0;
      in_val  = 1'b1;
      in_mode = 2'd0;
      in_data = 64'h5555_6666_7777_1111;
      cyc();
      in_val = 1'b0;
      cyc();
      #1;
      chk("inflight_present", 64'(out_val), 64'd1);
      rst = 1'b0;
      #1;
      chk("inflight_rst_val", 64'(out_val), 64'd0);
      chk("inflight_rst_data", out_data, 64'd0);
      cyc();
      rst     = 1'b1;
      out_rdy = 1'b1;
      for (int k = 0; k < 3; k++) begin
         cyc();
         #1;
         chk("inflight_no_emit", 64'(out_val), 64'd0);
      end

      // Random traffic against the reference model.
      sent     = 0;
      rcvd     = 0;
      zero_tot = 0;
      clip_tot = 0;
      fork
         begin : driver
            int          cnt;
            bit          pending;
            logic [63:0] d;
            logic [63:0] e;
            logic [1:0]  m;
            int          zc;
            int          cc;
            cnt     = 0;
            pending = 1'b0;
            d = '0; e = '0; m = '0; zc = 0; cc = 0;
            while (sent < NBEATS && cnt < BUDGET) begin
               cyc();
               cnt++;
               if (!pending && $urandom_range(3) != 0) begin
                  m  = 2'($urandom_range(3));
                  zc = 0;
                  cc = 0;
                  for (int l = 0; l < 4; l++) begin
                     d[l*16 +: 16] = rnd_elem();
                     e[l*16 +: 16] = model_lane(d[l*16 +: 16], m);
                     if (d[l*16 + 15] && (m == 2'd1 || m == 2'd3)) zc++;
                     if (m == 2'd3 && int'($signed(d[l*16 +: 16])) > 1536) cc++;
                  end
                  pending = 1'b1;
               end
               in_val  = pending;
               in_data = d;
               in_mode = m;
               #1;
               if (in_val && in_rdy) begin
                  exp_q.push_back(e);
                  zq.push_back(zc);
                  cq.push_back(cc);
                  pending = 1'b0;
                  sent++;
               end
            end
            cyc();
            in_val = 1'b0;
         end
         begin : monitor
            int          cnt;
            bit          stalled;
            logic [63:0] held;
            cnt     = 0;
            stalled = 1'b0;
            held    = '0;
            while (rcvd < NBEATS && cnt < BUDGET) begin
               cyc();
               cnt++;
               out_rdy = ($urandom_range(3) != 0);
               #1;
               if (stalled) begin
                  chk("rnd_hold_val", 64'(out_val), 64'd1);
                  chk("rnd_hold_data", out_data, held);
               end
               if (out_val && out_rdy) begin
                  if (exp_q.size() == 0) begin
                     chk("rnd_unexpected_beat", 64'd1, 64'd0);
                  end else begin
                     chk("rnd_data", out_data, exp_q.pop_front());
                     zero_tot += zq.pop_front();
                     clip_tot += cq.pop_front();
                  end
                  rcvd++;
               end
               stalled = out_val && !out_rdy;
               held    = out_data;
            end
         end
      join
      out_rdy = 1'b1;
      chk("rnd_sent", 64'(sent), 64'(NBEATS));
      chk("rnd_rcvd", 64'(rcvd), 64'(NBEATS));
      repeat (3) cyc();
      #1;
      chk("rnd_no_extra", 64'(out_val), 64'd0);
`ifdef ACTIVATION_PIPE_STATS_EN
      chk("zero_cnt", 64'(zero_cnt), 64'(zero_tot));
      chk("clip_cnt", 64'(clip_cnt), 64'(clip_tot));
`endif

      $display("[TB] %0d tests run, %0d failed", tests, fails);
      $finish;
   end

endmodule
